// File: rtl/x_tag_receiver.sv
// x_tag_receiver: receiving end of the tagged X-bus.
// Captures bus words whose tag matches this column's id into a small
// first-word-fall-through FIFO and hands them to the local PE through a
// valid/ready handshake.
//
// Optional feature: define X_RECV_BROADCAST_EN to also accept the all-ones
// tag as a broadcast in every instance.
//
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   x_id                - column id of this instance (registered before use)
//   from_Ybus_tag_x     - destination column tag on the bus
//   from_Ybus_enable    - bus word valid this cycle
//   from_Ybus_value     - bus data
//   to_Ybus_ready       - receiver can accept a word (FIFO not full)
//   to_pe_valid         - FIFO head valid
//   to_pe_value         - FIFO head data (zero when not valid)
//   from_pe_ready       - PE consumes the head this cycle
//   fifo_count          - current occupancy
//   overflow_err        - sticky: matching word arrived while full
module x_tag_receiver #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TAG_W-1:0]           x_id,
    input  logic [TAG_W-1:0]           from_Ybus_tag_x,
    input  logic                       from_Ybus_enable,
    input  logic [DATA_W-1:0]          from_Ybus_value,
    output logic                       to_Ybus_ready,
    output logic                       to_pe_valid,
    output logic [DATA_W-1:0]          to_pe_value,
    input  logic                       from_pe_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [TAG_W-1:0]  x_id_save;
    logic              tag_hit;
    logic              match;
    logic              full;
    logic              push;
    logic              pop;

    // Tag compare against the registered id; broadcast tag optionally accepted.
`ifdef X_RECV_BROADCAST_EN
    assign tag_hit = (from_Ybus_tag_x == x_id_save) ||
                     (from_Ybus_tag_x == {TAG_W{1'b1}});
`else
    assign tag_hit = (from_Ybus_tag_x == x_id_save);
`endif

    assign match         = from_Ybus_enable && tag_hit;
    assign full          = (fifo_count == CNT_W'(DEPTH));
    assign to_Ybus_ready = !full;
    assign push          = match && to_Ybus_ready;
    assign to_pe_valid   = (fifo_count != '0);
    assign pop           = to_pe_valid && from_pe_ready;
    assign to_pe_value   = to_pe_valid ? mem[rd_ptr] : '0;

    // Control state: id register, pointers, occupancy, sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_id_save    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            x_id_save <= x_id;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A matching word while full means the transmitter ignored ready.
            if (match && full) overflow_err <= 1'b1;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= from_Ybus_value;
    end

endmodule

// File: tb/tb_x_tag_receiver.sv
// Directed self-checking bench for x_tag_receiver (DEPTH=4, DATA_W=32, TAG_W=9).
module tb_x_tag_receiver;

    logic        clk;
    logic        rst;
    logic [8:0]  x_id;
    logic [8:0]  from_Ybus_tag_x;
    logic        from_Ybus_enable;
    logic [31:0] from_Ybus_value;
    logic        to_Ybus_ready;
    logic        to_pe_valid;
    logic [31:0] to_pe_value;
    logic        from_pe_ready;
    logic [2:0]  fifo_count;
    logic        overflow_err;

    int checks;
    int failures;
    int bc;

    x_tag_receiver #(.DEPTH(4), .DATA_W(32), .TAG_W(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .x_id             (x_id),
        .from_Ybus_tag_x  (from_Ybus_tag_x),
        .from_Ybus_enable (from_Ybus_enable),
        .from_Ybus_value  (from_Ybus_value),
        .to_Ybus_ready    (to_Ybus_ready),
        .to_pe_valid      (to_pe_valid),
        .to_pe_value      (to_pe_value),
        .from_pe_ready    (from_pe_ready),
        .fifo_count       (fifo_count),
        .overflow_err     (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_cnt"},   32'(fifo_count),    32'd0);
        chk({tag, "_rdy"},   32'(to_Ybus_ready), 32'd1);
        chk({tag, "_vld"},   32'(to_pe_valid),   32'd0);
        chk({tag, "_val"},   to_pe_value,        32'd0);
        chk({tag, "_ovf"},   32'(overflow_err),  32'd0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        x_id             = 9'd0;
        from_Ybus_tag_x  = 9'd0;
        from_Ybus_enable = 1'b0;
        from_Ybus_value  = 32'd0;
        from_pe_ready    = 1'b0;
`ifdef X_RECV_BROADCAST_EN
        bc = 1;
`else
        bc = 0;
`endif
        tick();
        tick();
        chk_all_reset("reset");

        // Release reset, load id 5.
        rst  = 1'b1;
        x_id = 9'd5;
        tick();

        // Single word: visible the cycle after acceptance.
        from_Ybus_tag_x  = 9'd5;
        from_Ybus_value  = 32'hDEADBEEF;
        from_Ybus_enable = 1'b1;
        tick();
        from_Ybus_enable = 1'b0;
        chk("single_vld", 32'(to_pe_valid), 32'd1);
        chk("single_val", to_pe_value,      32'hDEADBEEF);
        chk("single_cnt", 32'(fifo_count),  32'd1);
        from_pe_ready = 1'b1;
        tick();
        from_pe_ready = 1'b0;
        chk("single_pop_vld", 32'(to_pe_valid), 32'd0);
        chk("single_pop_val", to_pe_value,      32'd0);

        // Filtering: non-matching tag.
        from_Ybus_tag_x  = 9'd6;
        from_Ybus_value  = 32'h12345678;
        from_Ybus_enable = 1'b1;
        tick();
        from_Ybus_enable = 1'b0;
        chk("filter_cnt", 32'(fifo_count),   32'd0);
        chk("filter_ovf", 32'(overflow_err), 32'd0);

        // Fill to DEPTH with PE stalled.
        from_Ybus_tag_x  = 9'd5;
        from_Ybus_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            from_Ybus_value = 32'(i);
            tick();
            if (i == 3) begin
                chk("fill3_cnt", 32'(fifo_count),    32'd3);
                chk("fill3_rdy", 32'(to_Ybus_ready), 32'd1);
            end
        end
        chk("full_cnt", 32'(fifo_count),    32'd4);
        chk("full_rdy", 32'(to_Ybus_ready), 32'd0);
        chk("full_head", to_pe_value,       32'd1);

        // Overflow: matching word while full is dropped, flag sticks.
        from_Ybus_value = 32'd5;
        tick();
        from_Ybus_enable = 1'b0;
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_cnt",  32'(fifo_count),   32'd4);

        // Non-matching word while full raises nothing new (flag already set, count stays).
        from_Ybus_tag_x  = 9'd7;
        from_Ybus_enable = 1'b1;
        tick();
        from_Ybus_enable = 1'b0;
        from_Ybus_tag_x  = 9'd5;
        chk("full_nomatch_cnt", 32'(fifo_count), 32'd4);

        // Drain in order; ready returns the cycle after the first pop.
        from_pe_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d_vld", i), 32'(to_pe_valid), 32'd1);
            chk($sformatf("drain%0d_val", i), to_pe_value,      32'(i));
            tick();
            if (i == 1) chk("drain_rdy_back", 32'(to_Ybus_ready), 32'd1);
        end
        chk("drain_cnt",    32'(fifo_count),   32'd0);
        chk("drain_vld",    32'(to_pe_valid),  32'd0);
        chk("ovf_sticky",   32'(overflow_err), 32'd1);
        from_pe_ready = 1'b0;

        // Concurrent push/pop at count 2 with pointer wrap.
        from_Ybus_enable = 1'b1;
        from_Ybus_value  = 32'h10;
        tick();
        from_Ybus_value  = 32'h11;
        tick();
        chk("stream_pre_cnt", 32'(fifo_count), 32'd2);
        from_pe_ready = 1'b1;
        for (int k = 32'h12; k <= 32'h19; k++) begin
            from_Ybus_value = 32'(k);
            chk($sformatf("stream_head_%0h", k), to_pe_value, 32'(k - 2));
            tick();
            chk($sformatf("stream_cnt_%0h", k), 32'(fifo_count), 32'd2);
        end
        from_Ybus_enable = 1'b0;
        chk("stream_tail0", to_pe_value, 32'h18);
        tick();
        chk("stream_tail1", to_pe_value, 32'h19);
        tick();
        chk("stream_empty", 32'(fifo_count), 32'd0);
        from_pe_ready = 1'b0;

        // Broadcast tag with id 3.
        x_id = 9'd3;
        tick();
        from_Ybus_tag_x  = 9'h1FF;
        from_Ybus_value  = 32'hA5A5A5A5;
        from_Ybus_enable = 1'b1;
        tick();
        from_Ybus_enable = 1'b0;
        chk("bcast_cnt", 32'(fifo_count), 32'(bc));
        chk("bcast_val", to_pe_value,     (bc != 0) ? 32'hA5A5A5A5 : 32'd0);

        // New id takes effect; old contents are kept.
        from_Ybus_tag_x  = 9'd3;
        from_Ybus_value  = 32'h33;
        from_Ybus_enable = 1'b1;
        tick();
        chk("newid_cnt", 32'(fifo_count), 32'(bc + 1));
        chk("newid_head", to_pe_value,    (bc != 0) ? 32'hA5A5A5A5 : 32'h33);
        for (int i = bc + 1; i < 3; i++) begin
            from_Ybus_value = 32'h40 + 32'(i);
            tick();
        end
        from_Ybus_enable = 1'b0;
        chk("pre_reset_cnt", 32'(fifo_count), 32'd3);

        // Asynchronous reset mid-cycle with count 3.
        #2;
        rst = 1'b0;
        #1;
        chk_all_reset("midrst");
        #1;
        rst = 1'b1;
        tick();
        chk("post_rst_rdy", 32'(to_Ybus_ready), 32'd1);
        chk("post_rst_cnt", 32'(fifo_count),    32'd0);
        chk("post_rst_ovf", 32'(overflow_err),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
